// File: rtl/definition.sv
// Shared definitions for the attention datapath and its scheduler.
//   att_width   : datapath word width used by Attention_core
//   att_phase_t : scheduler phase encoding, visible on the phase port
//   att_err_t   : error cause reported on err_code
package definition;

   localparam int att_width = 16;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD_Q = 3'd1,
      LOAD_K = 3'd2,
      LOAD_V = 3'd3,
      SCORE  = 3'd4,
      DRAIN  = 3'd5,
      DONE   = 3'd6
   } att_phase_t;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_CFG     = 2'd1,
      ERR_TIMEOUT = 2'd2
   } att_err_t;

endpackage

// File: rtl/att_tok_counter.sv
// Modulo counter with a programmable terminal value.
//   clk, rstn : clock, synchronous active-low reset
//   clr       : force count to 0 (priority over inc)
//   inc       : advance by one, wrapping to 0 after term
//   term      : terminal value (modulus - 1)
//   count     : current value
//   last      : count equals term
module att_tok_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         clr,
   input  logic         inc,
   input  logic [W-1:0] term,
   output logic [W-1:0] count,
   output logic         last
);

   assign last = (count == term);

   always_ff @(posedge clk) begin
      if (!rstn || clr)
         count <= '0;
      else if (inc)
         count <= last ? '0 : count + W'(1);
   end

endmodule

// File: rtl/attention_scheduler.sv
// Sequencing controller for Attention_core: one layer per start, looping over
// heads; each head loads Q, K, V token streams, waits for the core score
// phase, then drains output tokens.
//   clk, rstn             : clock, synchronous active-low reset
//   start, abort          : layer start (IDLE only) / return to IDLE
//   cfg_tokens, cfg_heads : layer config, latched at an accepted start
//   in_valid / in_ready   : upstream token handshake
//   core_end / core_en    : core end flag / core enable
//   out_valid / out_ready : downstream token handshake
//   phase, tok_idx, head_idx, busy : status
//   done, err, err_code   : completion pulse, error pulse, error cause
module attention_scheduler
   import definition::*;
#(
   parameter int MAX_TOKENS    = 16,
   parameter int MAX_HEADS     = 4,
   parameter int SCORE_TIMEOUT = 255
) (
   input  logic                             clk,
   input  logic                             rstn,
   input  logic                             start,
   input  logic                             abort,
   input  logic [$clog2(MAX_TOKENS+1)-1:0]  cfg_tokens,
   input  logic [$clog2(MAX_HEADS+1)-1:0]   cfg_heads,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic                             core_end,
   output logic                             core_en,
   output logic                             out_valid,
   input  logic                             out_ready,
   output att_phase_t                       phase,
   output logic [$clog2(MAX_TOKENS)-1:0]    tok_idx,
   output logic [$clog2(MAX_HEADS)-1:0]     head_idx,
   output logic                             busy,
   output logic                             done,
   output logic                             err,
   output logic [1:0]                       err_code
);

   localparam int TW  = $clog2(MAX_TOKENS + 1);
   localparam int IW  = $clog2(MAX_TOKENS);
   localparam int HW  = $clog2(MAX_HEADS + 1);
   localparam int HIW = $clog2(MAX_HEADS);
   localparam int CW  = $clog2(SCORE_TIMEOUT + 1);

   att_phase_t      state, nxt;
   logic [TW-1:0]   cfg_tok_q;
   logic [HW-1:0]   cfg_head_q;
   logic [CW-1:0]   tcnt;
   logic            cfg_ok, accept, bad_cfg, t_out;
   logic            in_acc, out_acc, tok_last, head_last, cnt_clr;

   assign phase   = state;
   assign in_acc  = in_valid & in_ready;
   assign out_acc = out_valid & out_ready;
   assign cfg_ok  = (cfg_tokens != '0) && (cfg_tokens <= TW'(MAX_TOKENS)) &&
                    (cfg_heads  != '0) && (cfg_heads  <= HW'(MAX_HEADS));

   // Counters sit at 0 whenever the FSM is (or is about to be) idle, so an
   // accepted start always begins from index 0 and abort leaves them cleared.
   assign cnt_clr = (nxt == IDLE);

   att_tok_counter #(.W(IW)) u_tok (
      .clk   (clk),
      .rstn  (rstn),
      .clr   (cnt_clr),
      .inc   (in_acc | out_acc),
      .term  (IW'(cfg_tok_q - TW'(1))),
      .count (tok_idx),
      .last  (tok_last)
   );

   att_tok_counter #(.W(HIW)) u_head (
      .clk   (clk),
      .rstn  (rstn),
      .clr   (cnt_clr),
      .inc   (out_acc & tok_last & ~head_last),
      .term  (HIW'(cfg_head_q - HW'(1))),
      .count (head_idx),
      .last  (head_last)
   );

   always_comb begin
      nxt     = state;
      accept  = 1'b0;
      bad_cfg = 1'b0;
      t_out   = 1'b0;
      if (abort) begin
         nxt = IDLE;
      end else begin
         case (state)
            IDLE:
               if (start) begin
                  if (cfg_ok) begin
                     accept = 1'b1;
                     nxt    = LOAD_Q;
                  end else begin
                     bad_cfg = 1'b1;
                  end
               end
            LOAD_Q: if (in_acc && tok_last) nxt = LOAD_K;
            LOAD_K: if (in_acc && tok_last) nxt = LOAD_V;
            LOAD_V: if (in_acc && tok_last) nxt = SCORE;
            SCORE:
               // tcnt counts completed SCORE cycles; the edge ending cycle
               // SCORE_TIMEOUT is the timeout point. core_end wins a tie.
               if (core_end) begin
                  nxt = DRAIN;
               end else if (tcnt == CW'(SCORE_TIMEOUT - 1)) begin
                  t_out = 1'b1;
                  nxt   = IDLE;
               end
            DRAIN:
               if (out_acc && tok_last) nxt = head_last ? DONE : LOAD_Q;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state      <= IDLE;
         in_ready   <= 1'b0;
         core_en    <= 1'b0;
         out_valid  <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         err_code   <= ERR_NONE;
         cfg_tok_q  <= '0;
         cfg_head_q <= '0;
         tcnt       <= '0;
      end else begin
         state     <= nxt;
         in_ready  <= (nxt == LOAD_Q) || (nxt == LOAD_K) || (nxt == LOAD_V);
         core_en   <= (nxt == SCORE) || (nxt == DRAIN);
         out_valid <= (nxt == DRAIN);
         busy      <= (nxt != IDLE);
         done      <= (nxt == DONE);
         err       <= bad_cfg | t_out;
         tcnt      <= (state == SCORE && nxt == SCORE) ? tcnt + CW'(1) : '0;
         if (bad_cfg) begin
            err_code <= ERR_CFG;
         end else if (t_out) begin
            err_code <= ERR_TIMEOUT;
         end else if (accept) begin
            err_code   <= ERR_NONE;
            cfg_tok_q  <= cfg_tokens;
            cfg_head_q <= cfg_heads;
         end
      end
   end

endmodule

// File: tb/tb_attention_scheduler.sv
module tb_attention_scheduler;
   import definition::*;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       start = 1'b0, abort = 1'b0;
   logic [4:0] cfg_tokens = '0;
   logic [2:0] cfg_heads = '0;
   logic       in_valid = 1'b0, core_end = 1'b0, out_ready = 1'b0;
   logic       in_ready, core_en, out_valid, busy, done, err;
   logic [1:0] err_code;
   logic [3:0] tok_idx;
   logic [1:0] head_idx;
   att_phase_t phase;

   int n_chk = 0, n_pass = 0;
   int n_in = 0, n_out = 0, n_done = 0;

   attention_scheduler #(
      .MAX_TOKENS(16), .MAX_HEADS(4), .SCORE_TIMEOUT(8)
   ) dut (
      .clk(clk), .rstn(rstn), .start(start), .abort(abort),
      .cfg_tokens(cfg_tokens), .cfg_heads(cfg_heads),
      .in_valid(in_valid), .in_ready(in_ready),
      .core_end(core_end), .core_en(core_en),
      .out_valid(out_valid), .out_ready(out_ready),
      .phase(phase), .tok_idx(tok_idx), .head_idx(head_idx),
      .busy(busy), .done(done), .err(err), .err_code(err_code)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (in_valid && in_ready)   n_in   <= n_in + 1;
      if (out_valid && out_ready) n_out  <= n_out + 1;
      if (done)                   n_done <= n_done + 1;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic check_idle(input string tag);
      check({tag, ".phase"},     phase,     IDLE);
      check({tag, ".in_ready"},  in_ready,  0);
      check({tag, ".core_en"},   core_en,   0);
      check({tag, ".out_valid"}, out_valid, 0);
      check({tag, ".busy"},      busy,      0);
      check({tag, ".done"},      done,      0);
      check({tag, ".err"},       err,       0);
      check({tag, ".tok_idx"},   tok_idx,   0);
      check({tag, ".head_idx"},  head_idx,  0);
      check({tag, ".err_code"},  err_code,  0);
   endtask

   // Runs one layer; the start cycle is cycle 1. core_end is raised in the
   // score_wait-th SCORE cycle. With disturb set, cycle 3 carries a start with
   // a different config and a stray core_end.
   task automatic run_layer(input int tok, input int heads, input int score_wait,
                            input bit disturb, output int t_en, output int t_done,
                            output int d_in, output int d_out);
      int cyc, sc, b_in, b_out;
      t_en = 0; t_done = 0; sc = 0;
      cfg_tokens = 5'(tok); cfg_heads = 3'(heads);
      in_valid = 1'b1; out_ready = 1'b1; core_end = 1'b0;
      b_in = n_in; b_out = n_out;
      start = 1'b1;
      tick;
      cyc = 2;
      start = 1'b0;
      for (int c = 0; c < 80; c++) begin
         start = 1'b0; core_end = 1'b0;
         if (phase == SCORE) begin
            sc++;
            core_end = (sc == score_wait);
         end
         if (disturb && cyc == 3) begin
            start = 1'b1; cfg_tokens = 5'd2; cfg_heads = 3'd3; core_end = 1'b1;
         end
         tick;
         cyc++;
         if (core_en && t_en == 0) t_en = cyc;
         if (done) begin
            t_done = cyc;
            break;
         end
      end
      start = 1'b0; core_end = 1'b0; in_valid = 1'b0;
      d_in = n_in - b_in; d_out = n_out - b_out;
   endtask

   initial begin
      int t_en, t_done, d_in, d_out, b_done, k;
      int b_in, b_out, nh;
      int ld[2], dr[2], hd[2];
      bit stalled;
      att_phase_t prev;

      // reset
      out_ready = 1'b1;
      tick; tick;
      check_idle("reset");
      rstn = 1'b1;
      tick;

      // basic layer: 4 tokens, 1 head, core_end in 5th SCORE cycle
      b_done = n_done;
      run_layer(4, 1, 5, 1'b0, t_en, t_done, d_in, d_out);
      check("basic.core_en_cycle", t_en, 14);
      check("basic.done_cycle", t_done, 23);
      check("basic.in_accepts", d_in, 12);
      check("basic.out_accepts", d_out, 4);
      tick;
      check("basic.done_count", n_done - b_done, 1);
      check("basic.busy_after", busy, 0);
      check("basic.done_after", done, 0);

      // backpressure, two heads, in_valid toggling
      cfg_tokens = 5'd3; cfg_heads = 3'd2; out_ready = 1'b1; in_valid = 1'b0;
      b_done = n_done;
      start = 1'b1;
      tick;
      start = 1'b0;
      b_in = n_in; b_out = n_out; nh = 0; stalled = 1'b0; prev = phase;
      ld = '{0, 0}; dr = '{0, 0}; hd = '{9, 9};
      for (int c = 0; c < 200; c++) begin
         in_valid = ~in_valid;
         core_end = (phase == SCORE);
         tick;
         if (phase == SCORE && prev != SCORE && nh < 2) begin
            hd[nh] = head_idx; ld[nh] = n_in - b_in; b_in = n_in;
         end
         if (prev == DRAIN && phase != DRAIN && nh < 2) begin
            dr[nh] = n_out - b_out; b_out = n_out; nh++;
         end
         if (phase == DRAIN && tok_idx == 1 && !stalled) begin
            stalled = 1'b1;
            out_ready = 1'b0;
            tick; tick;
            check("bp.stall_tok_idx", tok_idx, 1);
            check("bp.stall_phase", phase, DRAIN);
            out_ready = 1'b1;
         end
         prev = phase;
         if (done) break;
      end
      in_valid = 1'b0; core_end = 1'b0;
      check("bp.done_seen", done, 1);
      check("bp.head0_idx", hd[0], 0);
      check("bp.head1_idx", hd[1], 1);
      check("bp.head0_loads", ld[0], 9);
      check("bp.head1_loads", ld[1], 9);
      check("bp.head0_drains", dr[0], 3);
      check("bp.head1_drains", dr[1], 3);
      tick;
      check("bp.done_count", n_done - b_done, 1);

      // bad config
      cfg_tokens = 5'd0; cfg_heads = 3'd1; start = 1'b1;
      tick;
      start = 1'b0;
      check("badcfg0.err", err, 1);
      check("badcfg0.err_code", err_code, 1);
      check("badcfg0.busy", busy, 0);
      tick;
      check("badcfg0.err_pulse", err, 0);
      check("badcfg0.code_hold", err_code, 1);
      cfg_tokens = 5'd4; cfg_heads = 3'd5; start = 1'b1;
      tick;
      start = 1'b0;
      check("badcfg1.err", err, 1);
      check("badcfg1.err_code", err_code, 1);
      check("badcfg1.busy", busy, 0);
      check("badcfg1.phase", phase, IDLE);

      // score timeout
      b_done = n_done;
      cfg_tokens = 5'd1; cfg_heads = 3'd1; in_valid = 1'b1; start = 1'b1;
      tick;
      start = 1'b0;
      check("tmo.err_code_cleared", err_code, 0);
      for (int c = 0; c < 20 && phase != SCORE; c++) tick;
      check("tmo.score_reached", phase, SCORE);
      in_valid = 1'b0;
      k = 0;
      for (int c = 0; c < 20; c++) begin
         tick;
         k++;
         if (err) break;
      end
      check("tmo.err_delay", k, 8);
      check("tmo.err", err, 1);
      check("tmo.err_code", err_code, 2);
      check("tmo.phase", phase, IDLE);
      check("tmo.busy", busy, 0);
      tick;
      check("tmo.err_pulse", err, 0);
      check("tmo.no_done", n_done - b_done, 0);

      // abort in LOAD_K at tok_idx 2
      cfg_tokens = 5'd4; cfg_heads = 3'd1; in_valid = 1'b1; start = 1'b1;
      tick;
      start = 1'b0;
      for (int c = 0; c < 20 && !(phase == LOAD_K && tok_idx == 2); c++) tick;
      check("abort.reached", tok_idx, 2);
      abort = 1'b1;
      tick;
      abort = 1'b0; in_valid = 1'b0;
      check_idle("abort");

      // reset while in DRAIN, then a clean layer
      cfg_tokens = 5'd2; cfg_heads = 3'd1; in_valid = 1'b1; out_ready = 1'b0;
      start = 1'b1;
      tick;
      start = 1'b0;
      for (int c = 0; c < 30 && phase != DRAIN; c++) begin
         core_end = (phase == SCORE);
         tick;
      end
      core_end = 1'b0;
      check("rst.drain_reached", phase, DRAIN);
      b_done = n_done;
      rstn = 1'b0;
      tick;
      check_idle("rst");
      rstn = 1'b1;
      run_layer(2, 1, 1, 1'b0, t_en, t_done, d_in, d_out);
      check("rst.rerun_core_en_cycle", t_en, 8);
      check("rst.rerun_done_cycle", t_done, 11);
      check("rst.rerun_in", d_in, 6);
      check("rst.rerun_out", d_out, 2);
      tick;
      check("rst.done_count", n_done - b_done, 1);

      // ignored start while busy and core_end during LOAD_Q
      b_done = n_done;
      run_layer(4, 1, 5, 1'b1, t_en, t_done, d_in, d_out);
      check("ign.core_en_cycle", t_en, 14);
      check("ign.done_cycle", t_done, 23);
      check("ign.in_accepts", d_in, 12);
      check("ign.out_accepts", d_out, 4);
      tick;
      check("ign.done_count", n_done - b_done, 1);
      check("ign.busy_after", busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/attention_scheduler.md
# attention_scheduler

Sequencing controller for the Attention_core datapath. It runs one attention layer per `start`, looping over heads, and walks each head through the Q, K and V token loads, the score computation, and the output drain. It owns the token and head counters, the valid/ready handshakes on the token streams, the core enable, and error detection (bad config, core timeout). It sits between the layer-level control and Attention_core and drives `en` to the core.

## Interface
- `MAX_TOKENS`, default 16: upper bound for `cfg_tokens`.
- `MAX_HEADS`, default 4: upper bound for `cfg_heads`.
- `SCORE_TIMEOUT`, default 255: maximum cycles spent in SCORE waiting for `core_end`.

- `clk` in 1: single clock, rising edge.
- `rstn` in 1: reset, synchronous, active-low.
- `start` in 1: begin a layer; sampled only in IDLE.
- `abort` in 1: return to IDLE next cycle, no `done`.
- `cfg_tokens` in $clog2(MAX_TOKENS+1): tokens per head; latched at an accepted `start`.
- `cfg_heads` in $clog2(MAX_HEADS+1): heads per layer; latched at an accepted `start`.
- `in_valid` in 1: upstream token valid.
- `in_ready` out 1: scheduler accepts a token.
- `core_end` in 1: `end_flag` from Attention_core.
- `core_en` out 1: drives the core `en`.
- `out_valid` out 1: core output token valid downstream.
- `out_ready` in 1: downstream accepts.
- `phase` out att_phase_t (3 bits): current state.
- `tok_idx` out $clog2(MAX_TOKENS): current token index.
- `head_idx` out $clog2(MAX_HEADS): current head index.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at layer completion.
- `err` out 1: one-cycle pulse; the cause is in `err_code`.
- `err_code` out 2: 0 none, 1 bad config, 2 score timeout; holds until the next accepted `start`.

## Operation
- States: IDLE, LOAD_Q, LOAD_K, LOAD_V, SCORE, DRAIN, DONE.
- IDLE, `start` high:
  - Config is valid (1 ≤ `cfg_tokens` ≤ MAX_TOKENS and 1 ≤ `cfg_heads` ≤ MAX_HEADS): latch config, clear counters, go to LOAD_Q.
  - Config is invalid: stay in IDLE, pulse `err`, set `err_code`=1.
- LOAD_Q, LOAD_K, LOAD_V:
  - `in_ready`=1.
  - Each `in_valid & in_ready` increments `tok_idx`.
  - The accept at `tok_idx`==`cfg_tokens`-1 wraps `tok_idx` to 0 and advances to the next state (LOAD_Q→LOAD_K→LOAD_V→SCORE).
- SCORE:
  - `core_en`=1; the timeout counter starts at 0 and increments each cycle.
  - `core_end` seen: go to DRAIN.
  - Counter reaches SCORE_TIMEOUT without `core_end`: pulse `err`, set `err_code`=2, go to IDLE.
- DRAIN:
  - `core_en`=1 and `out_valid`=1; each `out_valid & out_ready` increments `tok_idx`.
  - Last accept, more heads remain: `head_idx`++ and go to LOAD_Q.
  - Last accept on the final head (`head_idx`==`cfg_heads`-1): go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- `core_end` outside SCORE is ignored.
- `start` while `busy` is ignored; the latched config is unchanged.
- `abort` has priority over every transition except reset. From any non-IDLE state the next state is IDLE, with no `done` and no `err`.
- All counters are unsigned and wrap only by the explicit rules above; there is no arithmetic overflow path.

## Timing
- Reset (`rstn`=0 at a clock edge), next cycle:
  - state IDLE;
  - `in_ready`, `core_en`, `out_valid`, `busy`, `done`, `err` = 0;
  - `tok_idx`, `head_idx`, `err_code` = 0.
- Reset mid-operation behaves the same; no partial `done`.
- All outputs are registered or decoded from state registers only; there are no combinational paths from inputs to outputs.
- `start` sampled at edge t: `busy`=1 and `in_ready`=1 from cycle t+1.
- Last LOAD_V accept at edge t: `core_en`=1 from t+1.
- `core_end` sampled at edge t: `out_valid`=1 from t+1.
- Last DRAIN accept at edge t: `done`=1 in cycle t+1; `busy`=0 from t+2.
- Minimum layer length per head is 3·`cfg_tokens` + score cycles + `cfg_tokens`, plus 1 cycle for DONE per layer.
- `in_valid` low stalls the loads indefinitely; `out_ready` low stalls DRAIN. There is no timeout on either.

## Structure
- Shared package `definition` holds:
  - `att_phase_t` enum: IDLE=0, LOAD_Q=1, LOAD_K=2, LOAD_V=3, SCORE=4, DRAIN=5, DONE=6;
  - `att_err_t` (2-bit error codes);
  - `att_width`, already used by the core.
- One sub-module, `att_tok_counter`: a loadable modulo-N counter with `inc` and `clr` inputs and a `last` output. It is instantiated for the token index and for the head index.
- The FSM and the timeout counter stay in `attention_scheduler`.

## Test plan
- Basic layer:
  - Stimulus: `cfg_tokens`=4, `cfg_heads`=1, `in_valid` held 1, `core_end` 5 cycles into SCORE, `out_ready`=1.
  - Required: 12 input accepts, `core_en` high from cycle 14, 4 output accepts, `done` pulse exactly once.
- Backpressure, two heads:
  - Stimulus: `cfg_tokens`=3, `cfg_heads`=2; `in_valid` toggles every cycle; `out_ready` low for 2 cycles mid-DRAIN.
  - Required: `head_idx` goes 0→1, each head takes 9 accepts and 3 drain accepts, one `done`.
- Bad config:
  - Stimulus: `start` with `cfg_tokens`=0, then `start` with `cfg_heads`=MAX_HEADS+1.
  - Required: each gives an `err` pulse with `err_code`=1, `busy` stays 0.
- Score timeout:
  - Stimulus: SCORE_TIMEOUT=8, `core_end` never asserted.
  - Required: `err` pulse with `err_code`=2, 8 cycles after SCORE entry; back in IDLE next cycle; no `done`.
- Abort and reset:
  - Stimulus 1: `abort` in LOAD_K at `tok_idx`=2. Required: IDLE next cycle, all outputs 0.
  - Stimulus 2: `rstn`=0 in DRAIN. Required: all outputs at reset values, then a new `start` runs cleanly to `done`.
- Ignored events:
  - Stimulus: `start` while busy, and `core_end` during LOAD_Q.
  - Required: no state or config change, and completion matches the undisturbed run.
